// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  mmio_pkg
//  Register offsets, CTRL bit layout and timer control struct for data_mem_mmio.
//  Revision: 1.0
// ============================================================================
package mmio_pkg;
`include "common.svh"

    localparam u32 LED_OFF   = 32'h0000_0000;
    localparam u32 SW_OFF    = 32'h0000_0004;
    localparam u32 COUNT_OFF = 32'h0000_0008;
    localparam u32 CMP_OFF   = 32'h0000_000C;
    localparam u32 CTRL_OFF  = 32'h0000_0010;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_AR_BIT    = 1;
    localparam int unsigned CTRL_IRQ_BIT   = 2;
    localparam int unsigned CTRL_MATCH_BIT = 3;

    // Field order mirrors the CTRL register: enable is bit 0, match is bit 3.
    typedef struct packed {
        u1 match;
        u1 irq_en;
        u1 auto_reload;
        u1 enable;
    } timer_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/common.svh
`default_nettype none
// ============================================================================
//  common.svh
//  Shared scalar/word typedefs for the core-side RTL.
//  Revision: 1.0
// ============================================================================
`ifndef COMMON_SVH
`define COMMON_SVH
typedef logic        u1;
typedef logic [31:0] u32;
`endif
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
//  mmio_timer
//  Free-running compare timer: COUNT, COMPARE and CTRL with sticky match flag.
//  Revision: 1.0
// ============================================================================
module mmio_timer
    import mmio_pkg::*;
(
    input  u1           clk,
    input  u1           rst_n,
    input  u1           i_count_we,
    input  u1           i_cmp_we,
    input  u1           i_ctrl_we,
    input  u32          i_wdata,
    output u32          o_count,
    output u32          o_compare,
    output timer_ctrl_t o_ctrl,
    output u1           o_match
);

    u32          r_count;
    u32          r_compare;
    timer_ctrl_t r_ctrl;
    u1           w_hit;

    // Compare always sees the registered COMPARE, so a same-cycle write uses the old value.
    assign w_hit = r_ctrl.enable && (r_count == r_compare);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_compare <= '1;
            r_ctrl    <= '0;
        end else begin
            if (i_count_we) begin
                r_count <= i_wdata;
            end else if (r_ctrl.enable) begin
                r_count <= (w_hit && r_ctrl.auto_reload) ? '0 : r_count + 32'd1;
            end

            if (i_cmp_we) begin
                r_compare <= i_wdata;
            end

            if (i_ctrl_we) begin
                r_ctrl.enable      <= i_wdata[CTRL_EN_BIT];
                r_ctrl.auto_reload <= i_wdata[CTRL_AR_BIT];
                r_ctrl.irq_en      <= i_wdata[CTRL_IRQ_BIT];
            end

            // A new match wins over a write-one-to-clear in the same cycle.
            if (w_hit) begin
                r_ctrl.match <= 1'b1;
            end else if (i_ctrl_we && i_wdata[CTRL_MATCH_BIT]) begin
                r_ctrl.match <= 1'b0;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ctrl    = r_ctrl;
    assign o_match   = r_ctrl.match;

endmodule
`default_nettype wire

// File: rtl/data_mem_mmio.sv
`default_nettype none
// ============================================================================
//  data_mem_mmio
//  Data RAM plus LED / switch / timer register page for the single-cycle core.
//  Revision: 1.0
// ============================================================================
module data_mem_mmio
    import mmio_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 64,
    parameter u32          MMIO_BASE = 32'h0000_FF00,
    parameter int unsigned LED_W     = 8
) (
    input  u1              clk,
    input  u1              reset,
    input  u1              memwrite,
    input  u32             addr,
    input  u32             writedata,
    output u32             readdata,
    input  logic [LED_W-1:0] sw_in,
    output logic [LED_W-1:0] led,
    output u1              timer_irq
);

    localparam int unsigned c_ram_aw    = $clog2(RAM_WORDS);
    localparam u32          c_ram_bytes = u32'(RAM_WORDS * 4);
    localparam u32          c_led_a     = MMIO_BASE + LED_OFF;
    localparam u32          c_sw_a      = MMIO_BASE + SW_OFF;
    localparam u32          c_count_a   = MMIO_BASE + COUNT_OFF;
    localparam u32          c_cmp_a     = MMIO_BASE + CMP_OFF;
    localparam u32          c_ctrl_a    = MMIO_BASE + CTRL_OFF;

    u32                  r_ram [RAM_WORDS];
    logic [LED_W-1:0]    r_led;
    logic [LED_W-1:0]    r_sw_meta;
    logic [LED_W-1:0]    r_sw_sync;

    u1                   w_ram_sel;
    u1                   w_led_sel;
    u1                   w_sw_sel;
    u1                   w_count_sel;
    u1                   w_cmp_sel;
    u1                   w_ctrl_sel;
    logic [c_ram_aw-1:0] w_ram_idx;
    u32                  w_count;
    u32                  w_compare;
    timer_ctrl_t         w_ctrl;
    u1                   w_match;

    // Register decode ignores addr[1:0]; RAM has priority if the regions ever overlap.
    assign w_ram_sel   = addr < c_ram_bytes;
    assign w_ram_idx   = addr[c_ram_aw+1:2];
    assign w_led_sel   = !w_ram_sel && (addr[31:2] == c_led_a[31:2]);
    assign w_sw_sel    = !w_ram_sel && (addr[31:2] == c_sw_a[31:2]);
    assign w_count_sel = !w_ram_sel && (addr[31:2] == c_count_a[31:2]);
    assign w_cmp_sel   = !w_ram_sel && (addr[31:2] == c_cmp_a[31:2]);
    assign w_ctrl_sel  = !w_ram_sel && (addr[31:2] == c_ctrl_a[31:2]);

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (memwrite && w_ram_sel) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
            if (memwrite && w_led_sel) begin
                r_led <= writedata[LED_W-1:0];
            end
        end
    end

    mmio_timer u_timer (
        .clk        (clk),
        .rst_n      (reset),
        .i_count_we (memwrite && w_count_sel),
        .i_cmp_we   (memwrite && w_cmp_sel),
        .i_ctrl_we  (memwrite && w_ctrl_sel),
        .i_wdata    (writedata),
        .o_count    (w_count),
        .o_compare  (w_compare),
        .o_ctrl     (w_ctrl),
        .o_match    (w_match)
    );

    always_comb begin
        readdata = '0;
        if (w_ram_sel) begin
            readdata = r_ram[w_ram_idx];
        end else if (w_led_sel) begin
            readdata = {{(32-LED_W){1'b0}}, r_led};
        end else if (w_sw_sel) begin
            readdata = {{(32-LED_W){1'b0}}, r_sw_sync};
        end else if (w_count_sel) begin
            readdata = w_count;
        end else if (w_cmp_sel) begin
            readdata = w_compare;
        end else if (w_ctrl_sel) begin
            readdata = {28'd0, w_ctrl};
        end
    end

    assign led       = r_led;
    assign timer_irq = w_match & w_ctrl.irq_en;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
`default_nettype none
// ============================================================================
//  tb_data_mem_mmio
//  Directed vector table plus hand sequences for timer, reset and switch paths.
//  Revision: 1.0
// ============================================================================
module tb_data_mem_mmio;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        memwrite  = 1'b0;
    logic [31:0] addr      = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [7:0]  sw_in     = 8'h00;
    logic [7:0]  led;
    logic        timer_irq;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_LED  = 32'h0000_FF00;
    localparam logic [31:0] A_SW   = 32'h0000_FF04;
    localparam logic [31:0] A_CNT  = 32'h0000_FF08;
    localparam logic [31:0] A_CMP  = 32'h0000_FF0C;
    localparam logic [31:0] A_CTRL = 32'h0000_FF10;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt [18];
    logic [31:0] exp_cnt [5];
    logic        exp_irq [5];

    data_mem_mmio #(
        .RAM_WORDS (64),
        .MMIO_BASE (32'h0000_FF00),
        .LED_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .sw_in     (sw_in),
        .led       (led),
        .timer_irq (timer_irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
        memwrite = 1'b0;
        addr     = a;
        #1;
        chk(nm, readdata, exp);
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        @(negedge clk);
        memwrite  = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vt[2]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF};
        vt[3]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0};
        vt[4]  = '{1'b1, 32'h0000_00FC, 32'h1234_5678, 32'h0};
        vt[5]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'h1234_5678};
        vt[6]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h0};
        vt[7]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0};
        vt[8]  = '{1'b1, 32'h0000_0400, 32'hAAAA_AAAA, 32'h0};
        vt[9]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111};
        vt[10] = '{1'b0, 32'h0000_0400, 32'h0,         32'h0};
        vt[11] = '{1'b1, A_LED,         32'h0000_01FF, 32'h0};
        vt[12] = '{1'b0, A_LED,         32'h0,         32'h0000_00FF};
        vt[13] = '{1'b0, A_CMP,         32'h0,         32'hFFFF_FFFF};
        vt[14] = '{1'b0, A_CNT,         32'h0,         32'h0};
        vt[15] = '{1'b0, A_CTRL,        32'h0,         32'h0};
        vt[16] = '{1'b0, 32'h0000_FF14, 32'h0,         32'h0};
        vt[17] = '{1'b0, 32'h0000_FEFC, 32'h0,         32'h0};

        exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state while reset is held
        repeat (2) @(negedge clk);
        #1;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        peek("rst_count", A_CNT, 32'h0);
        peek("rst_compare", A_CMP, 32'hFFFF_FFFF);
        peek("rst_ctrl", A_CTRL, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            if (vt[i].we) begin
                wr(vt[i].a, vt[i].d);
            end else begin
                peek($sformatf("vec%0d", i), vt[i].a, vt[i].exp);
                @(negedge clk);
            end
        end
        chk("led_port", 32'(led), 32'h0000_00FF);

        // Read of the word being written returns the old contents
        memwrite  = 1'b1;
        addr      = 32'h0000_0010;
        writedata = 32'hCAFE_F00D;
        #1;
        chk("ram_same_cycle_old", readdata, 32'hDEAD_BEEF);
        @(negedge clk);
        memwrite = 1'b0;
        #1;
        chk("ram_after_write", readdata, 32'hCAFE_F00D);
        @(negedge clk);

        // Auto-reload timer with COMPARE=3
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h7);
        for (int i = 0; i < 5; i++) begin
            peek($sformatf("reload_count%0d", i), A_CNT, exp_cnt[i]);
            chk($sformatf("reload_irq%0d", i), 32'(timer_irq), 32'(exp_irq[i]));
            if (i < 4) @(negedge clk);
        end
        wr(A_CTRL, 32'hF);
        peek("w1c_ctrl", A_CTRL, 32'h7);
        chk("w1c_irq_low", 32'(timer_irq), 32'h0);
        peek("w1c_count", A_CNT, 32'd1);
        repeat (3) @(negedge clk);
        peek("rematch_count", A_CNT, 32'd0);
        chk("rematch_irq", 32'(timer_irq), 32'h1);

        // Asynchronous reset mid-count
        #1 reset = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'h0);
        chk("async_rst_irq", 32'(timer_irq), 32'h0);
        chk("async_rst_count", readdata, 32'h0);
        peek("async_rst_ctrl", A_CTRL, 32'h0);
        peek("async_rst_compare", A_CMP, 32'hFFFF_FFFF);
        peek("ram_retained", 32'h0000_0010, 32'hCAFE_F00D);
        reset = 1'b1;
        @(negedge clk);

        // Wrap at FFFF_FFFF without reload; W1C in the match cycle loses
        wr(A_CNT, 32'hFFFF_FFFD);
        wr(A_CTRL, 32'h5);
        peek("wrap_fffd", A_CNT, 32'hFFFF_FFFD);
        @(negedge clk);
        peek("wrap_fffe", A_CNT, 32'hFFFF_FFFE);
        @(negedge clk);
        peek("wrap_ffff", A_CNT, 32'hFFFF_FFFF);
        chk("wrap_irq_before", 32'(timer_irq), 32'h0);
        wr(A_CTRL, 32'hD);
        peek("wrap_count0", A_CNT, 32'h0);
        chk("wrap_irq_set", 32'(timer_irq), 32'h1);
        peek("wrap_ctrl", A_CTRL, 32'hD);
        wr(A_CTRL, 32'hD);
        peek("wrap_count1", A_CNT, 32'd1);
        chk("wrap_irq_cleared", 32'(timer_irq), 32'h0);
        repeat (2) @(negedge clk);
        peek("wrap_count3", A_CNT, 32'd3);
        chk("wrap_no_rematch", 32'(timer_irq), 32'h0);

        // Software COUNT write in the match cycle
        wr(A_CTRL, 32'h0);
        wr(A_CNT, 32'd3);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h5);
        peek("sw_wr_c3", A_CNT, 32'd3);
        @(negedge clk);
        peek("sw_wr_c4", A_CNT, 32'd4);
        @(negedge clk);
        peek("sw_wr_c5", A_CNT, 32'd5);
        chk("sw_wr_irq_before", 32'(timer_irq), 32'h0);
        wr(A_CNT, 32'd100);
        peek("sw_wr_c100", A_CNT, 32'd100);
        chk("sw_wr_irq", 32'(timer_irq), 32'h1);
        @(negedge clk);
        peek("sw_wr_c101", A_CNT, 32'd101);

        // Switch synchroniser latency and read-only behaviour
        sw_in = 8'hA5;
        peek("sw_edge0", A_SW, 32'h0);
        @(negedge clk);
        peek("sw_edge1", A_SW, 32'h0);
        @(negedge clk);
        peek("sw_edge2", A_SW, 32'h0000_00A5);
        wr(A_SW, 32'h0000_0000);
        peek("sw_readonly", A_SW, 32'h0000_00A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
